stream_byte_buffer: RTL and testbench

//   Word-to-byte FIFO between the cores' 32-bit stream output and the SPI transmit path.

---
 rtl/stream_byte_buffer.sv | 119 +++++++++++
 tb/tb_stream_byte_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_byte_buffer.sv
// Word-in, byte-out FIFO with show-ahead byte output (MSB first); a pushed word is visible after one edge.
// Backpressure: word_ready_o drops when full, and a push while full is dropped and flagged in overflow_o.
module stream_byte_buffer #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 8,
  parameter logic [7:0]  EMPTY_BYTE = 8'h00
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DATA_WIDTH-1:0]      word_i,
  input  logic                       word_valid_i,
  output logic                       word_ready_o,
  input  logic                       flush_i,
  input  logic                       byte_req_i,
  output logic [7:0]                 byte_o,
  output logic                       byte_valid_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  full, empty, push, pop, pop_word;
  logic [DATA_WIDTH-1:0] head_shifted;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign push     = word_valid_i && !full;
  assign pop      = byte_req_i && !empty;
  assign pop_word = pop && (idx_q == IW'(NB - 1));

  // Shifting the head left by whole bytes puts byte k in the top lane.
  assign head_shifted = mem_q[rd_ptr_q] << {idx_q, 3'b000};

  assign word_ready_o = !full;
  assign byte_valid_o = !empty;
  assign byte_o       = empty ? EMPTY_BYTE : head_shifted[DATA_WIDTH-1 -: 8];
  assign level_o      = level_q;
  assign overflow_o   = ovf_q;
  assign underflow_o  = unf_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    level_d  = level_q;
    ovf_d    = ovf_q | (word_valid_i && full);
    unf_d    = unf_q | (byte_req_i && empty);

    if (push) begin
      mem_d[wr_ptr_q] = word_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      if (pop_word) begin
        idx_d    = '0;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    case ({push, pop_word})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Flush discards any push/pop in the same cycle, including a partial word.
    if (flush_i) begin
      mem_d    = mem_q;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      idx_d    = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage needs no reset: level/pointers gate every read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_stream_byte_buffer.sv
// Bench for stream_byte_buffer: directed scenarios plus random traffic against a word-queue model.
module tb_stream_byte_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int NB    = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] word_i;
  logic          word_valid_i;
  logic          word_ready_o;
  logic          flush_i;
  logic          byte_req_i;
  logic [7:0]    byte_o;
  logic          byte_valid_o;
  logic [3:0]    level_o;
  logic          overflow_o;
  logic          underflow_o;

  stream_byte_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .EMPTY_BYTE(8'h00)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .flush_i      (flush_i),
    .byte_req_i   (byte_req_i),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .level_o      (level_o),
    .overflow_o   (overflow_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: queue of whole words plus how many bytes of the head are gone.
  logic [DW-1:0] m_q[$];
  int            m_bidx;
  logic          m_ovf;
  logic          m_unf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_byte();
    logic [DW-1:0] w;
    if (m_q.size() == 0) return 8'h00;
    w = m_q[0];
    return 8'((w >> (8 * (NB - 1 - m_bidx))) & 32'hFF);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_bidx = 0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_step(input logic flush, input logic vld, input logic [DW-1:0] w,
                            input logic req);
    bit was_empty, was_full;
    if (flush) begin
      model_clear();
      return;
    end
    was_empty = (m_q.size() == 0);
    was_full  = (m_q.size() == DEPTH);
    if (req) begin
      if (was_empty) m_unf = 1'b1;
      else if (m_bidx == NB - 1) begin
        void'(m_q.pop_front());
        m_bidx = 0;
      end else m_bidx++;
    end
    if (vld) begin
      if (was_full) m_ovf = 1'b1;
      else m_q.push_back(w);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_level"}, 32'(level_o), 32'(m_q.size()));
    check_eq({tag, "_ready"}, 32'(word_ready_o), 32'(m_q.size() < DEPTH));
    check_eq({tag, "_bvld"}, 32'(byte_valid_o), 32'(m_q.size() != 0));
    check_eq({tag, "_byte"}, 32'(byte_o), 32'(model_byte()));
    check_eq({tag, "_ovf"}, 32'(overflow_o), 32'(m_ovf));
    check_eq({tag, "_unf"}, 32'(underflow_o), 32'(m_unf));
  endtask

  // One clock: drive inputs, check pre-edge state at negedge, advance model at the edge.
  task automatic cycle(input string tag, input logic flush, input logic vld,
                       input logic [DW-1:0] w, input logic req);
    flush_i      = flush;
    word_valid_i = vld;
    word_i       = w;
    byte_req_i   = req;
    @(negedge clk_i);
    check_outputs(tag);
    @(posedge clk_i);
    model_step(flush, vld, w, req);
    #1;
    flush_i      = 1'b0;
    word_valid_i = 1'b0;
    byte_req_i   = 1'b0;
  endtask

  task automatic push(input string tag, input logic [DW-1:0] w);
    cycle(tag, 1'b0, 1'b1, w, 1'b0);
  endtask

  task automatic pop(input string tag);
    cycle(tag, 1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    int pushed, cyc;
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    word_valid_i = 1'b0;
    word_i       = '0;
    byte_req_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_clear();

    check_eq("rst_level", 32'(level_o), 0);
    check_eq("rst_ready", 32'(word_ready_o), 1);
    check_eq("rst_bvld", 32'(byte_valid_o), 0);
    check_eq("rst_byte", 32'(byte_o), 0);
    check_eq("rst_flags", {30'd0, overflow_o, underflow_o}, 0);

    // 1: single word, MSB first
    push("t1_push", 32'hDEADBEEF);
    check_eq("t1_b0", 32'(byte_o), 32'hDE);
    check_eq("t1_lvl1", 32'(level_o), 1);
    pop("t1_p0");
    check_eq("t1_b1", 32'(byte_o), 32'hAD);
    pop("t1_p1");
    check_eq("t1_b2", 32'(byte_o), 32'hBE);
    pop("t1_p2");
    check_eq("t1_b3", 32'(byte_o), 32'hEF);
    pop("t1_p3");
    check_eq("t1_lvl0", 32'(level_o), 0);
    check_eq("t1_bvld0", 32'(byte_valid_o), 0);
    check_eq("t1_empty_byte", 32'(byte_o), 0);

    // 2: fill, then overflow
    for (int i = 0; i < DEPTH; i++) push("t2_fill", 32'(i));
    check_eq("t2_lvl8", 32'(level_o), 8);
    check_eq("t2_rdy0", 32'(word_ready_o), 0);
    push("t2_ninth", 32'h0000_0008);
    check_eq("t2_ovf", 32'(overflow_o), 1);
    check_eq("t2_lvl8b", 32'(level_o), 8);

    // 3: final-byte pop while full with a push attempt
    for (int i = 0; i < 3; i++) pop("t3_pop");
    cycle("t3_both", 1'b0, 1'b1, 32'h0000_0009, 1'b1);
    check_eq("t3_rdy1", 32'(word_ready_o), 1);
    check_eq("t3_lvl7", 32'(level_o), 7);
    check_eq("t3_head", 32'(byte_o), 32'h00);
    for (int i = 0; i < 7 * NB; i++) pop("t3_drain");
    check_eq("t3_empty", 32'(level_o), 0);

    // 4: underflow then flush
    cycle("t4_flush0", 1'b1, 1'b0, '0, 1'b0);
    pop("t4_under");
    check_eq("t4_unf", 32'(underflow_o), 1);
    check_eq("t4_lvl", 32'(level_o), 0);
    cycle("t4_flush", 1'b1, 1'b0, '0, 1'b0);
    check_eq("t4_unf_clr", 32'(underflow_o), 0);

    // 5: 20 random words, random gaps, pointers wrap
    pushed = 0;
    cyc    = 0;
    while ((pushed < 20 || m_q.size() != 0) && cyc < 2000) begin
      logic vld, req;
      logic [DW-1:0] w;
      vld = (pushed < 20) && ($urandom_range(0, 1) == 1) && (m_q.size() < DEPTH);
      req = ($urandom_range(0, 9) < 6) && (m_q.size() != 0);
      w   = $urandom;
      cycle("t5", 1'b0, vld, w, req);
      if (vld) pushed++;
      cyc++;
    end
    check_eq("t5_done", 32'(cyc < 2000), 1);
    check_eq("t5_pushed", 32'(pushed), 20);

    // Random mix including overflow/underflow/flush; model tracks everything
    for (int i = 0; i < 300; i++) begin
      cycle("rnd", ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), $urandom,
            ($urandom_range(0, 1) == 1));
    end

    // 6: flush mid-word
    cycle("t6_flush0", 1'b1, 1'b0, '0, 1'b0);
    push("t6_push1", 32'h11223344);
    pop("t6_p0");
    pop("t6_p1");
    check_eq("t6_mid", 32'(byte_o), 32'h33);
    cycle("t6_flush", 1'b1, 1'b0, '0, 1'b0);
    push("t6_push2", 32'hAABBCCDD);
    check_eq("t6_byte", 32'(byte_o), 32'hAA);
    check_eq("t6_lvl", 32'(level_o), 1);
    pop("t6_after");
    check_eq("t6_byte2", 32'(byte_o), 32'hBB);

    // Mid-word reset restarts at byte 0
    pop("t7_p");
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_clear();
    check_eq("t7_rst_lvl", 32'(level_o), 0);
    push("t7_push", 32'hCAFEF00D);
    check_eq("t7_byte", 32'(byte_o), 32'hCA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
